// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: turns CPU byte/word requests into 16-bit bus
// cycles, splitting misaligned words into two byte-lane cycles, with
// wait-state handling and a bounded-wait timeout. All outputs registered.
module mem_access_sequencer #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned WCNT_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_word,
   input  logic              req_write,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_be,
   output logic              mem_read,
   output logic              mem_write,
   output logic              odd_address,
   output logic              word,
   output logic              phase,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CYC1 = 3'd1,
      CYC2 = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_e;

   localparam logic [WCNT_W-1:0] WAIT_LIM   = WCNT_W'(WAIT_MAX);
   localparam bit                TIMEOUT_EN = (WAIT_MAX != 0);

   state_e              state_q, state_d;
   logic [ADDR_W-1:1]   addr_q, addr_d;
   logic                odd_q, odd_d;
   logic                word_q, word_d;
   logic                write_q, write_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [1:0]          mem_be_q, mem_be_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic                phase_q, phase_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;

   logic [ADDR_W-1:0]   base_addr;

   // State, latched request fields, wait counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         odd_q       <= 1'b0;
         word_q      <= 1'b0;
         write_q     <= 1'b0;
         wcnt_q      <= '0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         phase_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         odd_q       <= odd_d;
         word_q      <= word_d;
         write_q     <= write_d;
         wcnt_q      <= wcnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         phase_q     <= phase_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   // Next state: request capture, wait counting, split and timeout decisions
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      odd_d   = odd_q;
      word_d  = word_q;
      write_d = write_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               addr_d  = req_addr[ADDR_W-1:1];
               odd_d   = req_addr[0];
               word_d  = req_word;
               write_d = req_write;
               wcnt_d  = '0;
               state_d = CYC1;
            end
         end
         CYC1, CYC2: begin
            if (mem_ready) begin
               if (state_q == CYC1 && odd_q && word_q) begin
                  state_d = CYC2;
                  wcnt_d  = '0;
               end else begin
                  state_d = DONE;
               end
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
               if (TIMEOUT_EN && wcnt_q == WAIT_LIM) begin
                  state_d = ERR;
               end
            end
         end
         DONE, ERR: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Outputs decoded from the upcoming state so they appear registered
   always_comb begin
      base_addr   = {addr_d, 1'b0};
      mem_addr_d  = '0;
      mem_be_d    = '0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      phase_d     = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      case (state_d)
         CYC1: begin
            busy_d      = 1'b1;
            mem_addr_d  = base_addr;
            mem_read_d  = !write_d;
            mem_write_d = write_d;
            if (odd_d)       mem_be_d = 2'b10;
            else if (word_d) mem_be_d = 2'b11;
            else             mem_be_d = 2'b01;
         end
         CYC2: begin
            busy_d      = 1'b1;
            phase_d     = 1'b1;
            mem_addr_d  = base_addr + ADDR_W'(2);
            mem_be_d    = 2'b01;
            mem_read_d  = !write_d;
            mem_write_d = write_d;
         end
         DONE:    done_d  = 1'b1;
         ERR:     error_d = 1'b1;
         default: ;
      endcase
   end

   assign mem_addr    = mem_addr_q;
   assign mem_be      = mem_be_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign odd_address = odd_q;
   assign word        = word_q;
   assign phase       = phase_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule
